// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between an RV32 core and the data memory LSU.
// master: drives the request (req_i, we_i, size_i, unsigned_i, addr_i, wdata_i) and sees ready_o.
// slave:  returns ready_o and the response (rvalid_o, rdata_o, err_o).
interface data_mem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_i;
    logic              we_i;
    logic [1:0]        size_i;
    logic              unsigned_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic              ready_o;
    logic              rvalid_o;
    logic [31:0]       rdata_o;
    logic              err_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        input  ready_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        output ready_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Data memory with load/store unit: byte-lane stores, sign/zero-extended loads, error flagging.
// Latency: READ_LATENCY (1 or 2) cycles from accept edge to rvalid_o; one request per cycle.
// Backpressure: ready_o is low only while INIT (reset and optional array clear), high in RUN.
// Ports: clk_i, rst_ni (async, active low), bus (slave side of data_mem_lsu_if).
module data_mem_lsu #(
    parameter int ADDR_W         = 32,
    parameter int MEM_SIZE_IN_KB = 1,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    data_mem_lsu_if.slave  bus
);
    localparam int NO_OF_WORDS = MEM_SIZE_IN_KB * 1024 / 4;
    localparam int IDX_W       = $clog2(NO_OF_WORDS);
    // One extra bit so the byte capacity always fits, even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(NO_OF_WORDS * 4);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic               clr_we;
    logic               ready;

    logic [3:0][7:0]    mem [NO_OF_WORDS];

    logic [IDX_W-1:0]   idx;
    logic [1:0]         lane;
    logic               misalign;
    logic               out_of_range;
    logic               acc_err;
    logic               accept;

    logic [3:0]         st_be;
    logic [31:0]        st_dat;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [3:0]         mem_be;
    logic [31:0]        mem_dat;

    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        ld_dat;

    logic               s1_vld, s1_err;
    logic [31:0]        s1_dat;

    // ------------------------------------------------------------------
    // Init/run control
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        ready     = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    // One zero word per cycle; the last word's edge also moves to RUN.
                    clr_we = 1'b1;
                    if (clr_idx_q == IDX_W'(NO_OF_WORDS - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        clr_idx_d = clr_idx_q + 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign bus.ready_o = ready;
    assign accept      = bus.req_i && ready;

    // ------------------------------------------------------------------
    // Address decode and error detection
    // ------------------------------------------------------------------
    assign idx          = bus.addr_i[IDX_W+1:2];
    assign lane         = bus.addr_i[1:0];
    assign out_of_range = {1'b0, bus.addr_i} >= MEM_BYTES;

    always_comb begin
        misalign = 1'b0;
        unique case (bus.size_i)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = lane[0];
            2'b10:   misalign = |lane;
            default: misalign = 1'b1;   // size 11 is never legal
        endcase
    end

    assign acc_err = misalign || out_of_range;

    // ------------------------------------------------------------------
    // Store path: right-aligned data replicated so each enabled lane picks it up
    // ------------------------------------------------------------------
    always_comb begin
        st_be  = 4'b0000;
        st_dat = 32'h0;
        unique case (bus.size_i)
            2'b00: begin
                st_be  = 4'b0001 << lane;
                st_dat = {4{bus.wdata_i[7:0]}};
            end
            2'b01: begin
                st_be  = lane[1] ? 4'b1100 : 4'b0011;
                st_dat = {2{bus.wdata_i[15:0]}};
            end
            2'b10: begin
                st_be  = 4'b1111;
                st_dat = bus.wdata_i;
            end
            default: begin
                st_be  = 4'b0000;
                st_dat = 32'h0;
            end
        endcase
    end

    // The clear port and the store port share the single write port; they
    // never collide because stores are only accepted in RUN.
    assign mem_we  = clr_we || (accept && bus.we_i && !acc_err);
    assign mem_idx = clr_we ? clr_idx_q : idx;
    assign mem_be  = clr_we ? 4'b1111 : st_be;
    assign mem_dat = clr_we ? 32'h0 : st_dat;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][b] <= mem_dat[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path: the array is read combinationally at the accept edge, so a
    // store written on the previous edge is already visible.
    // ------------------------------------------------------------------
    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_dat = rd_word;
        unique case (bus.size_i)
            2'b00:   ld_dat = bus.unsigned_i ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   ld_dat = bus.unsigned_i ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ld_dat = rd_word;
        endcase
    end

    // ------------------------------------------------------------------
    // Response pipeline; reset drops anything in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld <= 1'b0;
            s1_err <= 1'b0;
            s1_dat <= 32'h0;
        end else begin
            s1_vld <= accept;
            s1_err <= accept && acc_err;
            s1_dat <= (accept && !bus.we_i && !acc_err) ? ld_dat : 32'h0;
        end
    end

    // Any READ_LATENCY other than 2 is built as latency 1.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic        s2_vld, s2_err;
            logic [31:0] s2_dat;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    s2_vld <= 1'b0;
                    s2_err <= 1'b0;
                    s2_dat <= 32'h0;
                end else begin
                    s2_vld <= s1_vld;
                    s2_err <= s1_err;
                    s2_dat <= s1_dat;
                end
            end

            assign bus.rvalid_o = s2_vld;
            assign bus.err_o    = s2_err;
            assign bus.rdata_o  = s2_dat;
        end else begin : g_lat1
            assign bus.rvalid_o = s1_vld;
            assign bus.err_o    = s1_err;
            assign bus.rdata_o  = s1_dat;
        end
    endgenerate
endmodule
